// File: rtl/uart_pkg.sv
// Shared types and widths for the debug UART receive path.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_AXIS_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; a full FIFO still accepts a push when it pops in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && !empty_q;
        do_push  = push_i && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver feeding a small FIFO with a 32-bit valid/ready stream output.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rxd,
    output logic [UART_AXIS_WIDTH-1:0] m_axis_rdata,
    output logic                       m_axis_rvalid,
    input  logic                       m_axis_rready,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

    logic                      rxd_meta_q, rxd_s_q;
    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          limit_m1;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      sample;
    logic                      push;
    logic                      pop;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

    // Two-flop synchronizer, idle-high after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        limit_m1 = (state_q == START) ? CNT_W'(CLKS_PER_BIT / 2 - 1)
                                      : CNT_W'(CLKS_PER_BIT - 1);
        sample   = (cnt_q == limit_m1);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxd_s_q) state_d = START;
            end
            START: begin
                if (sample) begin
                    if (!rxd_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {rxd_s_q, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                if (sample) begin
                    if (rxd_s_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s_q) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q == IDLE || state_q == BREAK || sample || state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign pop       = m_axis_rvalid && m_axis_rready;
    assign overrun_d = push && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign m_axis_rdata  = {{(UART_AXIS_WIDTH - UART_DATA_BITS){1'b0}}, fifo_rdata};
    assign m_axis_rvalid = !fifo_empty;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis against a byte-queue model of the receive path.
module tb_uart_rx_axis;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [31:0] m_axis_rdata;
    logic        m_axis_rvalid;
    logic        m_axis_rready;
    logic        frame_err;
    logic        overrun;

    always #5 clk = ~clk;

    uart_rx_axis #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .m_axis_rdata  (m_axis_rdata),
        .m_axis_rvalid (m_axis_rvalid),
        .m_axis_rready (m_axis_rready),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    int          checks = 0;
    int          errors = 0;
    int          fe_seen = 0;
    int          ov_seen = 0;
    int          exp_fe = 0;
    int          exp_ov = 0;
    int          extra_beats = 0;
    logic [7:0]  exp_q[$];
    logic        stall_q = 1'b0;
    logic [31:0] stall_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: a good frame delivers its byte unless four are already waiting with no consumer.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (exp_q.size() >= int'(DEPTH) && !m_axis_rready) exp_ov++;
            else exp_q.push_back(b);
        end else begin
            exp_fe++;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop_ok;
        model_frame(b, stop_ok);
        tick(CPB);
    endtask

    task automatic end_scenario(input string name);
        m_axis_rready = 1'b1;
        tick(3 * DEPTH);
        check({name, "_rvalid_idle"}, 32'(m_axis_rvalid), 32'd0);
        check({name, "_undelivered"}, 32'(exp_q.size()), 32'd0);
        check({name, "_frame_err"}, 32'(fe_seen), 32'(exp_fe));
        check({name, "_overrun"}, 32'(ov_seen), 32'(exp_ov));
        check({name, "_extra_beats"}, 32'(extra_beats), 32'd0);
    endtask

    // Observes beats, flag pulse cycles and stall stability between clock edges.
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && m_axis_rvalid) check("rdata_stable", m_axis_rdata, stall_data);
            if (m_axis_rvalid && m_axis_rready) begin
                if (exp_q.size() > 0) begin
                    check("beat", m_axis_rdata, {24'h0, exp_q[0]});
                    void'(exp_q.pop_front());
                end else begin
                    extra_beats++;
                end
            end
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            stall_q    = m_axis_rvalid && !m_axis_rready;
            stall_data = m_axis_rdata;
        end
    end

    initial begin
        logic [7:0] b;
        logic       ok;

        rst = 1'b1;
        rxd = 1'b1;
        m_axis_rready = 1'b0;
        tick(3);
        check("rst_rvalid", 32'(m_axis_rvalid), 32'd0);
        check("rst_rdata", m_axis_rdata, 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(5);

        m_axis_rready = 1'b1;
        send(8'hA5, 1'b1);
        tick(4);
        end_scenario("single");

        m_axis_rready = 1'b0;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        tick(2);
        check("b2b_head_valid", 32'(m_axis_rvalid), 32'd1);
        check("b2b_head_data", m_axis_rdata, 32'h0000_0000);
        end_scenario("b2b");

        m_axis_rready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        tick(2);
        check("ovr_none_at_4", 32'(ov_seen), 32'd0);
        send(8'h05, 1'b1);
        tick(2);
        check("ovr_one_at_5", 32'(ov_seen), 32'd1);
        end_scenario("overrun");

        m_axis_rready = 1'b1;
        send(8'h3C, 1'b0);
        tick(40 * CPB);
        check("brk_single_fe", 32'(fe_seen), 32'(exp_fe));
        rxd = 1'b1;
        tick(2 * CPB);
        send(8'h3C, 1'b1);
        tick(4);
        end_scenario("break");

        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(2 * CPB);
        check("glitch_no_beat", 32'(extra_beats), 32'd0);
        check("glitch_no_fe", 32'(fe_seen), 32'(exp_fe));
        send(8'h7E, 1'b1);
        tick(4);
        end_scenario("glitch");

        m_axis_rready = 1'b0;
        send(8'($urandom), 1'b1);
        send(8'($urandom), 1'b1);
        tick(2);
        check("rst_mid_queued", 32'(m_axis_rvalid), 32'd1);
        b = 8'($urandom);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = b[4];
        tick(CPB / 2);
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", 32'(m_axis_rvalid), 32'd0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        rxd = 1'b1;
        tick(2 * CPB);
        check("rst_mid_empty", 32'(m_axis_rvalid), 32'd0);
        send(8'hC3, 1'b1);
        tick(4);
        end_scenario("reset_mid");

        m_axis_rready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send(b, ok);
            if (!ok) begin
                rxd = 1'b1;
                tick($urandom_range(4, 20));
            end else begin
                tick($urandom_range(0, 20));
            end
        end
        tick(4);
        end_scenario("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

Serial 8N1 UART receiver with a small receive FIFO and a 32-bit valid/ready stream output. It fills the receive path of the debug UART: its stream output connects directly to the `m_axis_rdata`/`m_axis_rvalid`/`m_axis_rready` side of `axi2axis`. Received bytes therefore become readable by the core over AXI-lite. It is the receiving counterpart to the existing transmit stream.

## Interface
- `CLKS_PER_BIT`, 868: clk cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥ 2.

- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rxd` in 1: asynchronous serial input, idle high.
- `m_axis_rdata` out 32: `{24'h0, byte}` at the FIFO head.
- `m_axis_rvalid` out 1: FIFO not empty.
- `m_axis_rready` in 1: consumer accepts the head byte.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a valid byte is dropped because the FIFO is full.

## Operation
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value `rxd_s`.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. It clears on every state entry and on every sample. A sample occurs when `cnt == LIMIT-1`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rxd_s == 0` → START.
  - START (LIMIT = `CLKS_PER_BIT/2`): on sample, `rxd_s == 0` → DATA with `bit_idx = 0`; `rxd_s == 1` is a glitch → IDLE, with no output and no flag.
  - DATA (LIMIT = `CLKS_PER_BIT`): on each sample, shift `rxd_s` into the shift register LSB-first. After the 8th sample → STOP.
  - STOP (LIMIT = `CLKS_PER_BIT`): on sample, `rxd_s == 1` pushes the byte and goes to IDLE. `rxd_s == 0` pulses `frame_err`, discards the byte, and goes to BREAK.
  - BREAK: stays until `rxd_s == 1` → IDLE. A line held low never produces a second `frame_err` and never retriggers a frame.
- FIFO behaviour:
  - First-word fall-through.
  - Pop when `m_axis_rvalid && m_axis_rready`.
  - A push when full with no pop in the same cycle drops the new byte and pulses `overrun`; stored data is untouched.
  - A push and pop in the same cycle while full are both accepted, with no overrun.
  - Push and pop in the same cycle while non-empty leave the occupancy unchanged.
- `m_axis_rdata` is stable while `m_axis_rvalid` is high and `m_axis_rready` is low. The upper 24 bits are always 0.

## Timing
- Reset values:
  - Outputs: `m_axis_rvalid = 0`, `m_axis_rdata = 0`, `frame_err = 0`, `overrun = 0`.
  - Internal: FSM in IDLE, FIFO empty, synchronizer at 1.
  - Reset asserted mid-frame abandons the frame and empties the FIFO. The next complete frame after release is received correctly.
- Input latency: a falling edge on `rxd` reaches `rxd_s` 2 cycles later.
- Sample points: mid-start at `CLKS_PER_BIT/2` cycles after START entry, then every `CLKS_PER_BIT`.
- Output latency: `m_axis_rvalid` rises the cycle after the stop-bit sample, when the FIFO was empty.
- `frame_err` and `overrun` are registered. Each asserts in the cycle after the stop-bit sample, for exactly 1 cycle.
- Back-to-back frames: a start bit immediately following a stop bit is detected with no lost cycles, because IDLE is entered mid-stop-bit.
- Occupancy counter is `$clog2(FIFO_DEPTH)+1` bits. Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;`
  - `UART_DATA_BITS = 8`
  - `UART_AXIS_WIDTH = 32`
- Sub-module `sync_fifo` with parameters WIDTH=8 and DEPTH=`FIFO_DEPTH`. It has push/pop/full/empty ports and the same clk/rst. It is reusable for a future TX-side buffer.
- The top instantiates the synchronizer, FSM and counter, and `sync_fifo`.

## Test plan
All scenarios use `CLKS_PER_BIT = 16` and `FIFO_DEPTH = 4`.
- Single frame 0xA5, ready=1 → one beat with `m_axis_rdata = 32'h000000A5`; `frame_err = 0`, `overrun = 0`.
- Back-to-back frames 0x00, 0xFF, 0x55 with ready=0, then ready=1 → beats 0x00, 0xFF, 0x55 in order; `m_axis_rvalid` drops after the third beat.
- Five frames 0x01–0x05 with ready=0 → exactly one `overrun` pulse, at the 5th stop bit. Draining yields 0x01–0x04 only.
- Stop bit driven 0 on frame 0x3C, line held low for 40 bit times, then frame 0x3C sent → exactly one `frame_err` pulse and no beat for the bad frame; the final valid frame yields 0x3C.
- `rxd` low for 4 cycles (less than 8) then high → returns to IDLE with no beat and no flags. A following frame 0x7E is received correctly.
- `rst` pulsed during bit 4 of a frame with 2 bytes already queued → `m_axis_rvalid = 0` immediately and the queue is empty. The next frame 0xC3 yields 0xC3.
